// File: rtl/apb_mem_wbuf.sv
// Word-array memory stage behind the APB slave, fronted by a posted-write FIFO with byte-level read forwarding.
// Optional access statistics are compiled in with `define APB_MEM_STATS_EN.
module apb_mem_wbuf #(
    parameter int ADDR_WIDTH = 10,
    parameter int DATA_WIDTH = 32,
    parameter int WBUF_DEPTH = 4
) (
    input  logic                           clk,
    input  logic                           rst_n,
    input  logic                           mem_wr,
    input  logic                           mem_rd,
    input  logic [DATA_WIDTH/8-1:0]        mem_be,
    input  logic [ADDR_WIDTH-1:0]          mem_address,
    input  logic [DATA_WIDTH-1:0]          mem_data_in,
    output logic [DATA_WIDTH-1:0]          mem_data_out,
    output logic [$clog2(WBUF_DEPTH):0]    wbuf_count,
    output logic                           wbuf_empty
`ifdef APB_MEM_STATS_EN
    ,
    output logic [15:0]                    rd_count,
    output logic [15:0]                    wr_count,
    output logic [15:0]                    fwd_count
`endif
);

    localparam int NB        = DATA_WIDTH / 8;
    localparam int LSB       = $clog2(NB);
    localparam int IW        = ADDR_WIDTH - LSB;
    localparam int MEM_WORDS = 1 << IW;
    localparam int SW        = $clog2(WBUF_DEPTH);
    localparam int PW        = SW + 1;

    logic [DATA_WIDTH-1:0] mem_q [MEM_WORDS];

    logic [IW-1:0]         idx_q  [WBUF_DEPTH];
    logic [NB-1:0]         be_q   [WBUF_DEPTH];
    logic [DATA_WIDTH-1:0] data_q [WBUF_DEPTH];

    logic [PW-1:0]         wr_ptr_q, wr_ptr_d;
    logic [PW-1:0]         rd_ptr_q, rd_ptr_d;
    logic [DATA_WIDTH-1:0] data_out_q, data_out_d;

    logic [IW-1:0]         word_idx;
    logic [PW-1:0]         count;
    logic                  empty;
    logic                  full;
    logic                  drain;
    logic                  rd_accept;
    logic                  fwd_hit;
    logic [DATA_WIDTH-1:0] rd_merged;
    logic [SW-1:0]         wr_slot;
    logic [SW-1:0]         rd_slot;

    generate
        if (LSB > 0) begin : g_lsb_unused
            logic unused_addr_lsb;
            assign unused_addr_lsb = ^mem_address[LSB-1:0];
        end
    endgenerate

    assign word_idx  = mem_address[ADDR_WIDTH-1:LSB];
    // Extra pointer bit separates full from empty when the slot bits are equal.
    assign count     = wr_ptr_q - rd_ptr_q;
    assign empty     = (wr_ptr_q == rd_ptr_q);
    assign full      = (wr_ptr_q[SW-1:0] == rd_ptr_q[SW-1:0]) && (wr_ptr_q[SW] != rd_ptr_q[SW]);
    assign drain     = !mem_rd && !empty;
    assign rd_accept = mem_rd && !mem_wr;
    assign wr_slot   = wr_ptr_q[SW-1:0];
    assign rd_slot   = rd_ptr_q[SW-1:0];

    always_comb begin
        logic [SW-1:0] slot;
        wr_ptr_d  = wr_ptr_q + {{(PW-1){1'b0}}, mem_wr};
        rd_ptr_d  = rd_ptr_q + {{(PW-1){1'b0}}, drain};
        rd_merged = mem_q[word_idx];
        fwd_hit   = 1'b0;
        slot      = '0;
        // Walk oldest to newest so the most recent write to a byte lands last.
        for (int i = 0; i < WBUF_DEPTH; i++) begin
            slot = rd_slot + SW'(i);
            if ((PW'(i) < count) && (idx_q[slot] == word_idx)) begin
                fwd_hit = 1'b1;
                for (int b = 0; b < NB; b++) begin
                    if (be_q[slot][b]) begin
                        rd_merged[8*b +: 8] = data_q[slot][8*b +: 8];
                    end
                end
            end
        end
        data_out_d = rd_accept ? rd_merged : data_out_q;
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            wr_ptr_q   <= '0;
            rd_ptr_q   <= '0;
            data_out_q <= '0;
        end else begin
            wr_ptr_q   <= wr_ptr_d;
            rd_ptr_q   <= rd_ptr_d;
            data_out_q <= data_out_d;
        end
    end

    // Storage without reset: entry validity comes from the pointers alone.
    always_ff @(posedge clk) begin
        if (mem_wr) begin
            idx_q[wr_slot]  <= word_idx;
            be_q[wr_slot]   <= mem_be;
            data_q[wr_slot] <= mem_data_in;
        end
        if (drain) begin
            for (int b = 0; b < NB; b++) begin
                if (be_q[rd_slot][b]) begin
                    mem_q[idx_q[rd_slot]][8*b +: 8] <= data_q[rd_slot][8*b +: 8];
                end
            end
        end
    end

    assign mem_data_out = data_out_q;
    assign wbuf_count   = count;
    assign wbuf_empty   = empty;

`ifdef APB_MEM_STATS_EN
    logic [15:0] rd_count_q, rd_count_d;
    logic [15:0] wr_count_q, wr_count_d;
    logic [15:0] fwd_count_q, fwd_count_d;

    always_comb begin
        rd_count_d  = rd_count_q;
        wr_count_d  = wr_count_q;
        fwd_count_d = fwd_count_q;
        if (rd_accept && rd_count_q != 16'hFFFF) begin
            rd_count_d = rd_count_q + 16'd1;
        end
        if (mem_wr && wr_count_q != 16'hFFFF) begin
            wr_count_d = wr_count_q + 16'd1;
        end
        if (rd_accept && fwd_hit && fwd_count_q != 16'hFFFF) begin
            fwd_count_d = fwd_count_q + 16'd1;
        end
    end

    always_ff @(posedge clk or negedge rst_n) begin
        if (!rst_n) begin
            rd_count_q  <= '0;
            wr_count_q  <= '0;
            fwd_count_q <= '0;
        end else begin
            rd_count_q  <= rd_count_d;
            wr_count_q  <= wr_count_d;
            fwd_count_q <= fwd_count_d;
        end
    end

    assign rd_count  = rd_count_q;
    assign wr_count  = wr_count_q;
    assign fwd_count = fwd_count_q;
`endif

`ifndef SYNTHESIS
    // Legal traffic can only reach a full buffer with a write that also drains.
    wbuf_no_overflow: assert property (@(posedge clk) disable iff (!rst_n)
        !(mem_wr && full && !drain));
`endif

endmodule

// File: tb/tb_apb_mem_wbuf.sv
// Self-checking bench for apb_mem_wbuf: byte-level reference memory, read scoreboard queue, per-cycle occupancy model.
module tb_apb_mem_wbuf;

    logic        clk = 1'b0;
    logic        rst_n;
    logic        mem_wr;
    logic        mem_rd;
    logic [3:0]  mem_be;
    logic [9:0]  mem_address;
    logic [31:0] mem_data_in;
    logic [31:0] mem_data_out;
    logic [2:0]  wbuf_count;
    logic        wbuf_empty;
`ifdef APB_MEM_STATS_EN
    logic [15:0] rd_count;
    logic [15:0] wr_count;
    logic [15:0] fwd_count;
`endif

    apb_mem_wbuf dut (
        .clk          (clk),
        .rst_n        (rst_n),
        .mem_wr       (mem_wr),
        .mem_rd       (mem_rd),
        .mem_be       (mem_be),
        .mem_address  (mem_address),
        .mem_data_in  (mem_data_in),
        .mem_data_out (mem_data_out),
        .wbuf_count   (wbuf_count),
        .wbuf_empty   (wbuf_empty)
`ifdef APB_MEM_STATS_EN
        ,
        .rd_count     (rd_count),
        .wr_count     (wr_count),
        .fwd_count    (fwd_count)
`endif
    );

    always #5 clk = ~clk;

    logic [31:0] ref_mem [256];
    bit          ref_known [256];
    logic [31:0] exp_q [$];
    bit          exp_v_q [$];
    int          checks = 0;
    int          failures = 0;
    int          exp_cnt = 0;
    logic [31:0] last_out = '0;
    bit          last_valid = 1'b1;

    task automatic check_eq(input string tag, input logic [31:0] got, input logic [31:0] exp);
        checks++;
        if (got !== exp) begin
            failures++;
            $display("FAIL %s got=%h exp=%h", tag, got, exp);
        end
    endtask

    // One clock of stimulus; outputs are checked 1ns after the capturing edge.
    task automatic cycle(input bit wr, input bit rd, input logic [3:0] be,
                         input logic [9:0] addr, input logic [31:0] data);
        int   w;
        bit   rd_ok;
        logic [31:0] e;
        bit   ev;
        w     = int'(addr[9:2]);
        rd_ok = rd && !wr;
        mem_wr      = wr;
        mem_rd      = rd;
        mem_be      = be;
        mem_address = addr;
        mem_data_in = data;
        if (rd_ok) begin
            exp_q.push_back(ref_mem[w]);
            exp_v_q.push_back(ref_known[w]);
        end
        if (wr) begin
            for (int b = 0; b < 4; b++) begin
                if (be[b]) ref_mem[w][8*b +: 8] = data[8*b +: 8];
            end
            if (be == 4'hF) ref_known[w] = 1'b1;
        end
        if (!rd && exp_cnt > 0) exp_cnt--;
        if (wr) exp_cnt++;
        @(posedge clk);
        #1;
        mem_wr = 1'b0;
        mem_rd = 1'b0;
        check_eq("wbuf_count", 32'(wbuf_count), 32'(exp_cnt));
        check_eq("wbuf_empty", 32'(wbuf_empty), 32'(exp_cnt == 0));
        if (rd_ok) begin
            if (exp_q.size() == 0) begin
                check_eq("scoreboard_underflow", 32'd1, 32'd0);
            end else begin
                e  = exp_q.pop_front();
                ev = exp_v_q.pop_front();
                if (ev) check_eq("rdata", mem_data_out, e);
                last_out   = e;
                last_valid = ev;
            end
        end else if (last_valid) begin
            check_eq("out_hold", mem_data_out, last_out);
        end
    endtask

    task automatic idle(input int n);
        for (int i = 0; i < n; i++) cycle(1'b0, 1'b0, 4'h0, 10'h0, 32'h0);
    endtask

    task automatic wr(input logic [9:0] addr, input logic [3:0] be, input logic [31:0] data);
        cycle(1'b1, 1'b0, be, addr, data);
    endtask

    task automatic rd(input logic [9:0] addr);
        cycle(1'b0, 1'b1, 4'h0, addr, 32'h0);
    endtask

    task automatic wr_viol(input logic [9:0] addr, input logic [3:0] be, input logic [31:0] data);
        cycle(1'b1, 1'b1, be, addr, data);
    endtask

    initial begin
        rst_n       = 1'b0;
        mem_wr      = 1'b0;
        mem_rd      = 1'b0;
        mem_be      = '0;
        mem_address = '0;
        mem_data_in = '0;
        repeat (2) @(posedge clk);
        #1;
        check_eq("reset_count", 32'(wbuf_count), 32'd0);
        check_eq("reset_empty", 32'(wbuf_empty), 32'd1);
        check_eq("reset_out", mem_data_out, 32'd0);
        rst_n = 1'b1;
        @(posedge clk);
        #1;

        // Forwarding, then one read that matches nothing in the buffer
        wr(10'h010, 4'hF, 32'hDEADBEEF);
        rd(10'h010);
        rd(10'h020);
`ifdef APB_MEM_STATS_EN
        check_eq("stat_rd", 32'(rd_count), 32'd2);
        check_eq("stat_wr", 32'(wr_count), 32'd1);
        check_eq("stat_fwd", 32'(fwd_count), 32'd1);
`endif
        idle(1);

        // Byte merge between array word and pending partial write
        wr(10'h000, 4'hF, 32'h11223344);
        idle(1);
        wr(10'h000, 4'b0101, 32'hAABBCCDD);
        rd(10'h000);
        idle(1);
        rd(10'h000);

        // Six back-to-back writes: occupancy stays at one
        for (int k = 0; k < 6; k++) wr(10'(10'h100 + 4*k), 4'hF, $urandom);
        idle(1);
        for (int k = 0; k < 6; k += 2) rd(10'(10'h100 + 4*k));

        // Fill to full with violation cycles, write while full, drain, read back
        wr_viol(10'h200, 4'hF, $urandom);
        wr_viol(10'h204, 4'hF, $urandom);
        wr_viol(10'h208, 4'hF, $urandom);
        wr_viol(10'h200, 4'h3, $urandom);
        rd(10'h200);
        wr(10'h204, 4'hC, $urandom);
        rd(10'h204);
        rd(10'h208);
        idle(4);
        rd(10'h200);
        rd(10'h204);
        rd(10'h208);

        // Reads hold off the drain
        wr(10'h040, 4'hF, $urandom);
        wr(10'h044, 4'hF, $urandom);
        idle(1);
        wr(10'h050, 4'hF, $urandom);
        wr_viol(10'h054, 4'hF, $urandom);
        rd(10'h040);
        rd(10'h044);
        rd(10'h050);
        idle(2);
        rd(10'h054);

        // Random mixed traffic over a small prefilled window
        for (int k = 0; k < 8; k++) wr(10'(10'h300 + 4*k), 4'hF, $urandom);
        idle(1);
        for (int k = 0; k < 60; k++) begin
            int op;
            logic [9:0] a;
            op = $urandom_range(0, 3);
            a  = 10'(10'h300 + 4*$urandom_range(0, 7));
            case (op)
                0: idle(1);
                1: wr(a, 4'($urandom_range(0, 15)), $urandom);
                2: rd(a);
                default: begin
                    if (exp_cnt < 4) wr_viol(a, 4'($urandom_range(0, 15)), $urandom);
                    else rd(a);
                end
            endcase
        end
        idle(4);
        for (int k = 0; k < 8; k++) rd(10'(10'h300 + 4*k));

        // Asynchronous reset with writes pending
        wr_viol(10'h3F0, 4'hF, $urandom);
        wr_viol(10'h3F4, 4'hF, $urandom);
        wr_viol(10'h3F8, 4'hF, $urandom);
        #2;
        rst_n = 1'b0;
        #1;
        check_eq("arst_count", 32'(wbuf_count), 32'd0);
        check_eq("arst_empty", 32'(wbuf_empty), 32'd1);
        check_eq("arst_out", mem_data_out, 32'd0);
        @(posedge clk);
        #1;
        rst_n      = 1'b1;
        exp_cnt    = 0;
        last_out   = '0;
        last_valid = 1'b1;
        idle(2);
        rd(10'h010);

        check_eq("scoreboard_drained", 32'(exp_q.size()), 32'd0);
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

endmodule
